// File: rtl/numeric_code_detonator_param.sv
// Programmable CODE_DIGITS-digit code detonator with retry lockout and fire countdown.
// Define NCD_LOCK_TIMEOUT_EN to make LOCKED expire after LOCK_CYCLES cycles.
module numeric_code_detonator_param #(
    parameter int CODE_DIGITS = 4,
    parameter int MAX_TRIES   = 3,
    parameter int FIRE_DELAY  = 8,
    parameter int LOCK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        setup,
    input  logic        ready,
    input  logic        sure,
    input  logic        fire,
    input  logic        wait_t,
    input  logic [9:0]  A,
    output logic [3:0]  m_disp,
    output logic [2:0]  state_o,
    output logic        lt,
    output logic        bt,
    output logic        rt,
    output logic        lb
);
    localparam int CW  = 4 * CODE_DIGITS;
    localparam int DCW = $clog2(CODE_DIGITS + 1);
    localparam int FCW = $clog2(FIRE_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SET    = 3'd1,
        S_ENTER  = 3'd2,
        S_ARMED  = 3'd3,
        S_COUNT  = 3'd4,
        S_BOOM   = 3'd5,
        S_LOCKED = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   code_q, code_d;
    logic            code_valid_q, code_valid_d;
    logic [DCW-1:0]  dig_cnt_q, dig_cnt_d;
    logic [3:0]      last_q, last_d;
    logic [3:0]      tries_q, tries_d;
    logic [FCW-1:0]  cnt_q, cnt_d;
    logic [9:0]      a_prev_q;
    logic [3:0]      m_disp_q, m_disp_d;
    logic            lt_q, bt_q, rt_q, lb_q;

`ifdef NCD_LOCK_TIMEOUT_EN
    localparam int LCW = $clog2(LOCK_CYCLES + 1);
    logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
`else
    logic            lock_cycles_unused;
    assign lock_cycles_unused = (LOCK_CYCLES < 1);
`endif

    logic        key_hot, key_ok, dig_full;
    logic [3:0]  key_val;
    logic [31:0] cnt_ext;

    // A key is taken only on the first cycle of a clean single press.
    always_comb begin
        key_hot = (A != '0) && ((A & (A - 10'd1)) == '0);
        key_ok  = key_hot && (a_prev_q == '0);
        key_val = '0;
        for (int i = 0; i < 10; i++) begin
            if (A[i]) key_val = 4'(i);
        end
        dig_full = (dig_cnt_q == DCW'(CODE_DIGITS));
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        dig_cnt_d    = dig_cnt_q;
        last_d       = last_q;
        tries_d      = tries_q;
        cnt_d        = cnt_q;
`ifdef NCD_LOCK_TIMEOUT_EN
        lock_cnt_d   = lock_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!wait_t && !sure && (setup || (ready && code_valid_q))) begin
                    state_d   = setup ? S_SET : S_ENTER;
                    buf_d     = '0;
                    dig_cnt_d = '0;
                    last_d    = '0;
                end
            end
            S_SET: begin
                if (wait_t) begin
                    state_d = S_IDLE;
                end else if (sure) begin
                    if (dig_full) begin
                        code_d       = buf_q;
                        code_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                    buf_d     = '0;
                    dig_cnt_d = '0;
                end else if (key_ok && !dig_full) begin
                    buf_d     = (buf_q << 4) | CW'(key_val);
                    dig_cnt_d = dig_cnt_q + 1'b1;
                    last_d    = key_val;
                end
            end
            S_ENTER: begin
                if (wait_t) begin
                    state_d = S_IDLE;
                end else if (sure) begin
                    if (dig_full && buf_q == code_q) begin
                        state_d = S_ARMED;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_q + 1'b1;
                        if (tries_d >= 4'(MAX_TRIES)) begin
                            state_d = S_LOCKED;
`ifdef NCD_LOCK_TIMEOUT_EN
                            lock_cnt_d = LCW'(LOCK_CYCLES);
`endif
                        end
                    end
                    buf_d     = '0;
                    dig_cnt_d = '0;
                end else if (key_ok && !dig_full) begin
                    buf_d     = (buf_q << 4) | CW'(key_val);
                    dig_cnt_d = dig_cnt_q + 1'b1;
                    last_d    = key_val;
                end
            end
            S_ARMED: begin
                if (wait_t) begin
                    state_d = S_IDLE;
                end else if (fire) begin
                    state_d = S_COUNT;
                    cnt_d   = FCW'(FIRE_DELAY);
                end
            end
            S_COUNT: begin
                if (wait_t) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == FCW'(1)) state_d = S_BOOM;
                end
            end
            S_BOOM: ;
            S_LOCKED: begin
`ifdef NCD_LOCK_TIMEOUT_EN
                // Lockout lasts exactly LOCK_CYCLES cycles; wait_t cannot cut it short.
                lock_cnt_d = lock_cnt_q - 1'b1;
                if (lock_cnt_q <= LCW'(1)) begin
                    state_d    = S_IDLE;
                    tries_d    = '0;
                    lock_cnt_d = '0;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with state_q.
    always_comb begin
        cnt_ext = 32'(cnt_d);
        case (state_d)
            S_SET, S_ENTER: m_disp_d = last_d;
            S_COUNT:        m_disp_d = (cnt_ext > 32'd9) ? 4'd9 : cnt_ext[3:0];
            default:        m_disp_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            dig_cnt_q    <= '0;
            last_q       <= '0;
            tries_q      <= '0;
            cnt_q        <= '0;
            a_prev_q     <= '0;
            m_disp_q     <= '0;
            lt_q         <= 1'b0;
            bt_q         <= 1'b0;
            rt_q         <= 1'b0;
            lb_q         <= 1'b0;
`ifdef NCD_LOCK_TIMEOUT_EN
            lock_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            dig_cnt_q    <= dig_cnt_d;
            last_q       <= last_d;
            tries_q      <= tries_d;
            cnt_q        <= cnt_d;
            a_prev_q     <= A;
            m_disp_q     <= m_disp_d;
            lt_q         <= (state_d == S_ENTER);
            bt_q         <= (state_d == S_ARMED) || (state_d == S_COUNT);
            rt_q         <= (state_d == S_BOOM);
            lb_q         <= (state_d == S_LOCKED);
`ifdef NCD_LOCK_TIMEOUT_EN
            lock_cnt_q   <= lock_cnt_d;
`endif
        end
    end

    assign m_disp  = m_disp_q;
    assign state_o = state_q;
    assign lt      = lt_q;
    assign bt      = bt_q;
    assign rt      = rt_q;
    assign lb      = lb_q;

endmodule

// File: tb/tb_numeric_code_detonator_param.sv
// Directed bench for numeric_code_detonator_param with default parameters (code 2581 scenarios).
module tb_numeric_code_detonator_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       setup = 1'b0, ready = 1'b0, sure = 1'b0, fire = 1'b0, wait_t = 1'b0;
    logic [9:0] A = '0;
    logic [3:0] m_disp;
    logic [2:0] state_o;
    logic       lt, bt, rt, lb;
    int         n_checks = 0;
    int         n_fail = 0;

    numeric_code_detonator_param dut (
        .clk(clk), .rst_n(rst_n), .setup(setup), .ready(ready), .sure(sure),
        .fire(fire), .wait_t(wait_t), .A(A), .m_disp(m_disp), .state_o(state_o),
        .lt(lt), .bt(bt), .rt(rt), .lb(lb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic press(input int d);
        A = 10'(1 << d); step(); A = '0; step();
    endtask

    task automatic do_setup(); setup = 1'b1; step(); setup = 1'b0; endtask
    task automatic do_ready(); ready = 1'b1; step(); ready = 1'b0; endtask
    task automatic do_sure();  sure  = 1'b1; step(); sure  = 1'b0; endtask
    task automatic do_fire();  fire  = 1'b1; step(); fire  = 1'b0; endtask
    task automatic do_wait();  wait_t = 1'b1; step(); wait_t = 1'b0; endtask

    task automatic keys_2581(); press(2); press(5); press(8); press(1); endtask

    task automatic do_reset();
        {setup, ready, sure, fire, wait_t} = '0;
        A = '0;
        rst_n = 1'b0; #3; rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; step(); step();
        n_checks++; if ({m_disp, state_o, lt, bt, rt, lb} !== 11'd0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 0", {m_disp, state_o, lt, bt, rt, lb}); end
        rst_n = 1'b1; step();
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_idle: state %0d expected 0", state_o); end
    endtask

    task automatic test_program_arm();
        do_reset();
        do_setup();
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL enter_set: state %0d expected 1", state_o); end
        keys_2581();
        n_checks++; if (m_disp !== 4'd1) begin n_fail++; $display("FAIL set_disp: m_disp %0d expected 1", m_disp); end
        do_sure();
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL store_code: state %0d expected 0", state_o); end
        do_ready();
        n_checks++; if (state_o !== 3'd2 || lt !== 1'b1) begin n_fail++; $display("FAIL enter_mode: state %0d lt %b expected 2/1", state_o, lt); end
        keys_2581();
        do_sure();
        n_checks++; if (state_o !== 3'd3 || bt !== 1'b1 || lt !== 1'b0) begin n_fail++; $display("FAIL armed: state %0d bt %b lt %b expected 3/1/0", state_o, bt, lt); end
    endtask

    task automatic test_fire();
        do_fire();
        n_checks++; if (state_o !== 3'd4 || m_disp !== 4'd8) begin n_fail++; $display("FAIL fire_start: state %0d m_disp %0d expected 4/8", state_o, m_disp); end
        for (int i = 7; i >= 1; i--) begin
            step();
            n_checks++; if (m_disp !== 4'(i) || rt !== 1'b0) begin n_fail++; $display("FAIL countdown: m_disp %0d rt %b expected %0d/0", m_disp, rt, i); end
        end
        step();
        n_checks++; if (rt !== 1'b1 || state_o !== 3'd5 || m_disp !== 4'd0) begin n_fail++; $display("FAIL boom: rt %b state %0d m_disp %0d expected 1/5/0", rt, state_o, m_disp); end
        for (int i = 0; i < 8; i++) begin
            {setup, ready, sure, fire, wait_t} = 5'($urandom);
            A = 10'($urandom);
            step();
            n_checks++; if (rt !== 1'b1 || state_o !== 3'd5) begin n_fail++; $display("FAIL boom_sticky: rt %b state %0d expected 1/5", rt, state_o); end
        end
        {setup, ready, sure, fire, wait_t} = '0;
        A = '0;
    endtask

    task automatic test_lockout();
        do_reset();
        do_setup(); keys_2581(); do_sure();
        do_ready();
        for (int t = 1; t <= 3; t++) begin
            press(1); press(1); press(1); press(1);
            do_sure();
            if (t < 3) begin
                n_checks++; if (state_o !== 3'd2 || lb !== 1'b0) begin n_fail++; $display("FAIL wrong_try: state %0d lb %b expected 2/0", state_o, lb); end
            end
        end
        n_checks++; if (state_o !== 3'd6 || lb !== 1'b1) begin n_fail++; $display("FAIL locked: state %0d lb %b expected 6/1", state_o, lb); end
        do_ready();
        n_checks++; if (state_o !== 3'd6) begin n_fail++; $display("FAIL locked_ready: state %0d expected 6", state_o); end
`ifdef NCD_LOCK_TIMEOUT_EN
        repeat (62) step();
        n_checks++; if (lb !== 1'b1) begin n_fail++; $display("FAIL lock_hold: lb %b expected 1", lb); end
        step();
        n_checks++; if (lb !== 1'b0 || state_o !== 3'd0) begin n_fail++; $display("FAIL lock_expire: lb %b state %0d expected 0/0", lb, state_o); end
`else
        repeat (80) step();
        n_checks++; if (lb !== 1'b1 || state_o !== 3'd6) begin n_fail++; $display("FAIL lock_terminal: lb %b state %0d expected 1/6", lb, state_o); end
`endif
    endtask

    task automatic test_key_filter();
        do_reset();
        do_setup(); keys_2581(); do_sure();
        do_ready();
        A = 10'b0000000110; step(); A = '0; step();
        n_checks++; if (m_disp !== 4'd0) begin n_fail++; $display("FAIL multi_hot: m_disp %0d expected 0", m_disp); end
        A = 10'(1 << 2); repeat (5) step(); A = '0; step();
        n_checks++; if (m_disp !== 4'd2) begin n_fail++; $display("FAIL held_key: m_disp %0d expected 2", m_disp); end
        press(5); press(8); press(1); press(9);
        n_checks++; if (m_disp !== 4'd1) begin n_fail++; $display("FAIL fifth_digit: m_disp %0d expected 1", m_disp); end
        do_sure();
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL filter_match: state %0d expected 3", state_o); end
    endtask

    task automatic test_aborts();
        do_fire();
        repeat (4) step();
        n_checks++; if (m_disp !== 4'd4) begin n_fail++; $display("FAIL abort_cnt: m_disp %0d expected 4", m_disp); end
        do_wait();
        n_checks++; if (state_o !== 3'd3 || bt !== 1'b1 || m_disp !== 4'd0) begin n_fail++; $display("FAIL abort_armed: state %0d bt %b m_disp %0d expected 3/1/0", state_o, bt, m_disp); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if (rt !== 1'b0) begin n_fail++; $display("FAIL abort_no_rt: rt %b expected 0", rt); end
        end
        do_wait();
        n_checks++; if (state_o !== 3'd0 || bt !== 1'b0) begin n_fail++; $display("FAIL disarm: state %0d bt %b expected 0/0", state_o, bt); end
        do_reset();
        do_ready();
        n_checks++; if (state_o !== 3'd0 || lt !== 1'b0) begin n_fail++; $display("FAIL ready_no_code: state %0d lt %b expected 0/0", state_o, lt); end
    endtask

    task automatic test_reset_countdown();
        do_reset();
        do_setup(); keys_2581(); do_sure();
        do_ready(); keys_2581(); do_sure();
        do_fire();
        repeat (5) step();
        n_checks++; if (m_disp !== 4'd3) begin n_fail++; $display("FAIL pre_reset_cnt: m_disp %0d expected 3", m_disp); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({m_disp, state_o, lt, bt, rt, lb} !== 11'd0) begin n_fail++; $display("FAIL async_reset: got %b expected 0", {m_disp, state_o, lt, bt, rt, lb}); end
        #2 rst_n = 1'b1;
        step();
        do_ready();
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_clears_code: state %0d expected 0", state_o); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_program_arm();
        test_fire();
        test_lockout();
        test_key_filter();
        test_aborts();
        test_reset_countdown();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/numeric_code_detonator_param.md
Name: numeric_code_detonator_param

Overview:
Parametrised successor to the numeric code detonator. It stores a programmable CODE_DIGITS-digit code entered on a one-hot 10-key pad and checks entered attempts against it. A MAX_TRIES lockout protects the code, and a FIRE_DELAY cycle countdown precedes detonation. It sits between the keypad/button debouncers and the display/LED drivers on the PYNQ-Z2 top level.

Parameters:
CODE_DIGITS, 4, digits per code (1..8); stored code width 4*CODE_DIGITS
MAX_TRIES, 3, wrong attempts before lockout (1..15)
FIRE_DELAY, 8, countdown cycles from fire to detonation (>=1)
LOCK_CYCLES, 64, lockout duration; used only with NCD_LOCK_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
setup  in  1  enter code-programming mode (level, sampled per cycle)
ready  in  1  enter code-entry mode
sure  in  1  confirm current digit buffer
fire  in  1  start countdown when armed
wait_t  in  1  abort/disarm
A  in  10  one-hot keypad, bit i = digit i
m_disp  out  4  display digit
state_o  out  3  FSM state, debug
lt  out  1  entry-mode light
bt  out  1  armed/countdown light
rt  out  1  detonation output, sticky
lb  out  1  lockout light

Behaviour:
- One clock domain. Reset is asynchronous, active-low. Reset clears state to IDLE, the stored code, code_valid, the buffer, digit count, tries and counters. All outputs reset to 0.
- Key accept: when A is exactly one-hot and A was all-zero on the previous cycle, the key is accepted that cycle. Multi-hot or held keys are ignored. The digit value is the index of the set bit.
- Each accepted digit shifts into the buffer and increments the count. Digits beyond CODE_DIGITS are ignored and the count saturates. m_disp shows the last accepted digit from the next cycle on.
- Priority within a cycle: wait_t > sure > key > fire > setup/ready.
- State encoding: IDLE=0, SET=1, ENTER=2, ARMED=3, COUNT=4, BOOM=5, LOCKED=6.
- IDLE:
  - setup -> SET.
  - ready with code_valid=1 -> ENTER.
  - ready with code_valid=0 is ignored.
  - The buffer and count are cleared on entry to SET or ENTER.
- SET:
  - Collect digits.
  - sure with count==CODE_DIGITS -> store the code, set code_valid=1, go to IDLE.
  - sure with count<CODE_DIGITS -> clear the buffer, stay in SET.
  - wait_t -> IDLE, stored code unchanged.
- ENTER:
  - Collect digits.
  - sure with full count and match -> ARMED, tries=0.
  - sure otherwise (short or mismatch) -> tries+1 and the buffer is cleared.
  - If tries reaches MAX_TRIES -> LOCKED, otherwise stay in ENTER.
  - wait_t -> IDLE; tries are kept.
- ARMED:
  - fire -> COUNT, with cnt loaded to FIRE_DELAY.
  - wait_t -> IDLE.
- COUNT:
  - cnt decrements each cycle.
  - The cycle in which cnt==1 transitions to BOOM, so rt rises exactly FIRE_DELAY edges after the edge that sampled fire.
  - wait_t aborts -> ARMED, cnt cleared.
  - m_disp = cnt, saturated to 9.
- BOOM: rt=1, held until reset. All inputs are ignored.
- LOCKED: lb=1. Without the macro, only reset exits this state.
- Lights: lt=1 in ENTER; bt=1 in ARMED or COUNT; rt=1 in BOOM; lb=1 in LOCKED.
- m_disp is 0 in IDLE, ARMED, BOOM and LOCKED.
- Compare is a full 4*CODE_DIGITS-bit equality on the buffer, with the first digit entered in the most significant nibble.

Optional Feature:
NCD_LOCK_TIMEOUT_EN
- Defined: entering LOCKED loads lock_cnt=LOCK_CYCLES. lock_cnt decrements each cycle; at 0 the FSM returns to IDLE with tries=0 and lb dropping. wait_t does not shorten the lockout.
- Undefined: LOCKED is terminal until rst_n is asserted, and LOCK_CYCLES is unused.

Test Plan:
1. Program and arm:
   - Stimulus: reset; setup; keys 2,5,8,1 (each press separated by A=0); sure; ready; keys 2,5,8,1; sure.
   - Required: state_o=3, bt=1, lt=0.
2. Fire:
   - Stimulus: from armed, fire sampled at edge k.
   - Required: m_disp counts 8..1; rt=1 at edge k+8; rt stays 1 while all inputs toggle.
3. Lockout:
   - Stimulus: code 2581 stored; enter 1111 + sure, three times.
   - Required: lb=1, state_o=6; ready ignored afterwards.
   - With NCD_LOCK_TIMEOUT_EN: lb drops after 64 cycles and state_o=0.
4. Key filtering:
   - Stimulus: A=10'b0000000110, then a held key for 5 cycles, then a 5th digit during ENTER.
   - Required: multi-hot gives no count; the held key counts once; the 5th digit is ignored; sure still matches.
5. Aborts:
   - Stimulus: wait_t during COUNT at cnt=4.
   - Required: state ARMED, rt never asserts; a second wait_t -> IDLE.
   - Stimulus: ready with no stored code.
   - Required: stays IDLE.
6. Reset mid-countdown:
   - Stimulus: rst_n low asynchronously at cnt=3.
   - Required: all outputs 0 immediately and code_valid cleared, so a following ready stays IDLE.
